sample_cal: RTL
===============

// Module: sample_cal
// PURPOSE
//  Per-channel calibration stage directly downstream of the AK4619 codec driver.
//  Takes the four raw signed ADC words once per sample period and computes
//  out = sat(((in - offset) * gain) >>> FRAC) for each channel.
//  One multiplier is time-shared across the channels by a small FSM.
//  Feeds the DSP core with one strobe per calibrated frame.
// PARAMETERS
//  W     16    sample/coefficient width, bits (signed)
//  FRAC  W-2   gain fraction bits; gain is signed Q2.FRAC, range [-2.0, 2.0)
// PORTS
//  clk          in   1      system clock; one clock domain
//  rst          in   1      synchronous reset, active-high
//  strobe_in    in   1      1-cycle pulse: raw_in* valid this cycle
//  raw_in0..3   in   W      raw signed ADC samples, ch0..ch3
//  bypass       in   1      1 = pass raw through unmodified (sampled at accept)
//  coef_we      in   1      coefficient write enable
//  coef_sel     in   3      {is_gain, ch[1:0]}: 0-3 offset ch0-3, 4-7 gain ch0-3
//  coef_data    in   W      coefficient value
//  cal_out0..3  out  W      calibrated samples, ch0..ch3
//  strobe_out   out  1      1-cycle pulse: cal_out* updated this cycle
//  busy         out  1      frame in progress
//  overrun      out  1      sticky: strobe_in arrived while busy
// BEHAVIOUR
//  Reset: cal_out*=0, strobe_out=0, busy=0, overrun=0, FSM=IDLE;
//   offsets=0, gains=1<<FRAC (unity). Reset mid-frame aborts it, no strobe_out.
//  FSM: IDLE -> (strobe_in) LATCH -> SUB(ch) -> MUL(ch) -> ... ch3 -> DONE -> IDLE.
//   LATCH (cycle 1 after accept): copy raw_in*, bypass, and all 8 coefficients
//   into frame registers; coefficients change only between frames.
//   Per channel: SUB forms d = in - offset at W+1 bits; MUL forms p = d*gain
//   at 2W+1 bits, q = p >>> FRAC (arith shift, truncate toward -inf), saturate
//   to [-2^(W-1), 2^(W-1)-1] into result reg.
//  Latency fixed: strobe_in at cycle 0 -> strobe_out high at cycle 10, 1 cycle.
//   All four cal_out* update together on the strobe_out cycle; held otherwise.
//  busy high from cycle 1 through cycle 10 inclusive.
//  strobe_in while busy (incl. strobe_out cycle): ignored, overrun<=1 until rst.
//  strobe_in in IDLE the cycle after strobe_out: accepted normally.
//  bypass=1: cal_out = raw_in exactly, same latency and strobe timing.
//  coef_we: writes live coefficient reg next cycle at any time; a write in the
//   same cycle as accept is NOT seen by that frame (seen by the next).
//  raw_in* only sampled on accept; values at other times are don't-care.
// STRUCTURE
//  Package sample_cal_pkg: N_CHANNELS=4, state_t enum {IDLE,LATCH,SUB,MUL,DONE},
//   coef_sel field decode constants, UNITY_GAIN function of FRAC.
//  Sub-module cal_mac: combinational-plus-one-register subtract/multiply/
//   shift/saturate datapath, parameterised on W and FRAC; FSM, channel
//   counter and coefficient banks stay in sample_cal.
// TESTING (W=16, FRAC=14)
//  Post-reset, strobe_in with raw=1000,-1000,0,32767 -> strobe_out at cycle 10,
//   outputs equal inputs (unity gain, zero offset).
//  ch1 offset=200, gain=8192 (0.5), raw1=1000 -> cal_out1=400; raw1=-1 ->
//   (-201*8192)>>>14 = -101 (floor).
//  Saturation: ch2 offset=-10000, gain=24576 (1.5), raw2=30000 -> 32767;
//   raw2=-32768, offset=10000 -> -32768.
//  Overrun: second strobe_in 4 cycles after first -> ignored, overrun=1,
//   exactly one strobe_out; overrun stays 1 until rst.
//  Coefficient write at cycle 0 and cycle 5 of a frame -> frame uses old
//   values; next frame uses new; bypass=1 frame returns raw values unchanged.
//  rst asserted at cycle 6 -> no strobe_out, all outputs 0, gains unity, next
//   strobe_in processed normally.

Source files
------------

// File: rtl/sample_cal_pkg.sv
// Shared types and constants for the per-channel sample calibration stage.
package sample_cal_pkg;

    localparam int unsigned DEF_W         = 16;
    localparam int unsigned N_CHANNELS    = 4;
    localparam int unsigned CH_W          = 2;
    localparam int unsigned COEF_SEL_W    = 3;
    localparam int unsigned COEF_GAIN_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SUB,
        MUL,
        DONE
    } state_t;

    // Unity gain in Q2.FRAC format.
    function automatic logic [31:0] unity_gain(input int unsigned frac);
        return 32'(1) << frac;
    endfunction

endpackage

// File: rtl/cal_mac.sv
// Subtract / multiply / arithmetic-shift / saturate datapath for one channel at a time.
module cal_mac #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = W - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sub_en,
    input  logic [W-1:0] raw_i,
    input  logic [W-1:0] offset_i,
    input  logic [W-1:0] gain_i,
    output logic [W-1:0] result_c
);

    localparam int unsigned DW = W + 1;
    localparam int unsigned PW = 2 * W + 1;

    logic signed [DW-1:0] d_q, d_d;
    logic signed [PW-1:0] p_c, q_c;
    logic        [W+1:0]  hi_c;
    logic                 fits_c;

    always_comb begin
        d_d = d_q;
        if (sub_en) begin
            d_d = DW'(signed'(raw_i)) - DW'(signed'(offset_i));
        end
    end

    // Floor shift of the product; fits when all bits above the result sign agree.
    always_comb begin
        p_c      = PW'(d_q) * PW'(signed'(gain_i));
        q_c      = p_c >>> FRAC;
        hi_c     = q_c[PW-1:W-1];
        fits_c   = (&hi_c) | ~(|hi_c);
        result_c = q_c[W-1:0];
        if (!fits_c) begin
            result_c = q_c[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/sample_cal.sv
// Four-channel offset/gain calibration with one time-shared multiplier.
module sample_cal
    import sample_cal_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned FRAC = W - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe_in,
    input  logic [W-1:0]          raw_in0,
    input  logic [W-1:0]          raw_in1,
    input  logic [W-1:0]          raw_in2,
    input  logic [W-1:0]          raw_in3,
    input  logic                  bypass,
    input  logic                  coef_we,
    input  logic [COEF_SEL_W-1:0] coef_sel,
    input  logic [W-1:0]          coef_data,
    output logic [W-1:0]          cal_out0,
    output logic [W-1:0]          cal_out1,
    output logic [W-1:0]          cal_out2,
    output logic [W-1:0]          cal_out3,
    output logic                  strobe_out,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [W-1:0]    UNITY   = W'(unity_gain(FRAC));
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);

    typedef logic [W-1:0] word_t;

    word_t raw_in_c [N_CHANNELS];

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;

    word_t off_q    [N_CHANNELS], off_d    [N_CHANNELS];
    word_t gain_q   [N_CHANNELS], gain_d   [N_CHANNELS];
    word_t raw_f_q  [N_CHANNELS], raw_f_d  [N_CHANNELS];
    word_t off_f_q  [N_CHANNELS], off_f_d  [N_CHANNELS];
    word_t gain_f_q [N_CHANNELS], gain_f_d [N_CHANNELS];
    word_t res_q    [N_CHANNELS], res_d    [N_CHANNELS];
    word_t cal_q    [N_CHANNELS], cal_d    [N_CHANNELS];

    logic  byp_f_q, byp_f_d;
    logic  strobe_out_q, strobe_out_d;
    logic  busy_q, busy_d;
    logic  overrun_q, overrun_d;

    word_t mac_result_c;
    word_t chan_res_c;

    assign raw_in_c[0] = raw_in0;
    assign raw_in_c[1] = raw_in1;
    assign raw_in_c[2] = raw_in2;
    assign raw_in_c[3] = raw_in3;

    cal_mac #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .sub_en   (state_q == SUB),
        .raw_i    (raw_f_q[ch_q]),
        .offset_i (off_f_q[ch_q]),
        .gain_i   (gain_f_q[ch_q]),
        .result_c (mac_result_c)
    );

    assign chan_res_c = byp_f_q ? raw_f_q[ch_q] : mac_result_c;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        off_d        = off_q;
        gain_d       = gain_q;
        raw_f_d      = raw_f_q;
        off_f_d      = off_f_q;
        gain_f_d     = gain_f_q;
        res_d        = res_q;
        cal_d        = cal_q;
        byp_f_d      = byp_f_q;
        strobe_out_d = 1'b0;
        overrun_d    = overrun_q;

        if (coef_we) begin
            if (coef_sel[COEF_GAIN_BIT]) begin
                gain_d[coef_sel[CH_W-1:0]] = coef_data;
            end else begin
                off_d[coef_sel[CH_W-1:0]] = coef_data;
            end
        end

        if (strobe_in && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            // Frame snapshot taken from the pre-write live bank on the accept edge.
            IDLE: begin
                if (strobe_in) begin
                    state_d  = LATCH;
                    ch_d     = '0;
                    raw_f_d  = raw_in_c;
                    off_f_d  = off_q;
                    gain_f_d = gain_q;
                    byp_f_d  = bypass;
                end
            end
            LATCH: state_d = SUB;
            SUB:   state_d = MUL;
            MUL: begin
                res_d[ch_q] = chan_res_c;
                if (ch_q == LAST_CH) begin
                    state_d      = DONE;
                    strobe_out_d = 1'b1;
                    cal_d        = res_d;
                end else begin
                    state_d = SUB;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            byp_f_q      <= 1'b0;
            strobe_out_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                off_q[i]    <= '0;
                gain_q[i]   <= UNITY;
                raw_f_q[i]  <= '0;
                off_f_q[i]  <= '0;
                gain_f_q[i] <= UNITY;
                res_q[i]    <= '0;
                cal_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            byp_f_q      <= byp_f_d;
            strobe_out_q <= strobe_out_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            off_q        <= off_d;
            gain_q       <= gain_d;
            raw_f_q      <= raw_f_d;
            off_f_q      <= off_f_d;
            gain_f_q     <= gain_f_d;
            res_q        <= res_d;
            cal_q        <= cal_d;
        end
    end

    assign cal_out0   = cal_q[0];
    assign cal_out1   = cal_q[1];
    assign cal_out2   = cal_q[2];
    assign cal_out3   = cal_q[3];
    assign strobe_out = strobe_out_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
